// File: rtl/uart_pkg.sv
// Shared definitions for the uart_8bit transmitter and receiver: state codes,
// frame constants and the baud counter sizing helper.
package uart_pkg;

   // estado decodes identically on both ends of the link.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   localparam int DATA_BITS              = 8;
   localparam int CLKS_PER_BIT_50M_57600 = 868;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP,
      GAP   = ST_GAP
   } uart_state_e;

   function automatic int baud_cnt_w(input int clks_per_bit);
      return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
   endfunction

endpackage

// File: rtl/uart_8bit_tx_if.sv
// Request/status bundle between a byte producer and the uart_8bit_tx serialiser.
interface uart_8bit_tx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] Tx_reg;
   logic                 send;
   logic                 Tx_data;
   logic                 busy;
   logic                 listo;
   logic [2:0]           estado;

   modport master (output Tx_reg, send, input Tx_data, busy, listo, estado);
   modport slave  (input Tx_reg, send, output Tx_data, busy, listo, estado);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_end pulses on the last clk of each CLKS_PER_BIT period;
// restart holds the count at zero so the next period starts cleanly.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_57600
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_end
);

   localparam int            CW   = baud_cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_cfg
      $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
   end

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_end = (cnt_q == LAST);

   // NOTE: always_comb assigns every output on every path, so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || bit_end) cnt_d = '0;
   end

   // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_8bit_tx.sv
// 8N1/8N2 asynchronous frame serialiser with an optional forced idle gap
// between frames; all line and status outputs are registered.
module uart_8bit_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_57600,
   parameter int STOP_BITS    = 1,
   parameter int IDLE_GAP     = 1
) (
   input logic           clk,
   input logic           rst,
   uart_8bit_tx_if.slave bus
);

   // Anything other than two stop bits collapses to one.
   localparam logic [3:0] STOP_LAST = (STOP_BITS == 2) ? 4'd1 : 4'd0;
   localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [3:0]           slot_q, slot_d;
   logic                 tx_data_q, tx_data_d;
   logic                 busy_q, busy_d;
   logic                 listo_q, listo_d;
   logic                 bit_end;

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk    (clk),
      .rst    (rst),
      .restart(state_q == IDLE),
      .bit_end(bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      slot_d    = slot_q;
      case (state_q)
         IDLE: if (bus.send) begin
            state_d = START;
            shift_d = bus.Tx_reg;
         end
         START: if (bit_end) begin
            state_d   = DATA;
            bit_idx_d = '0;
         end
         DATA: if (bit_end) begin
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
               state_d = STOP;
               slot_d  = '0;
            end else begin
               bit_idx_d = bit_idx_q + 3'd1;
               shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            end
         end
         STOP: if (bit_end) begin
            if (slot_q == STOP_LAST) begin
               slot_d  = '0;
               state_d = (IDLE_GAP > 0) ? GAP : IDLE;
            end else begin
               slot_d = slot_q + 4'd1;
            end
         end
         GAP: if (bit_end) begin
            if (slot_q == GAP_LAST) begin
               slot_d  = '0;
               state_d = IDLE;
            end else begin
               slot_d = slot_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs follow the state being entered so they line up with it.
      tx_data_d = 1'b1;
      if (state_d == START)     tx_data_d = 1'b0;
      else if (state_d == DATA) tx_data_d = shift_d[0];
      busy_d  = (state_d != IDLE);
      listo_d = (state_q != IDLE) && (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         // NOTE: the shift register is reset as well so an aborted frame leaves no stale byte.
         shift_q   <= '0;
         bit_idx_q <= '0;
         slot_q    <= '0;
         tx_data_q <= 1'b1;
         busy_q    <= 1'b0;
         listo_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         slot_q    <= slot_d;
         tx_data_q <= tx_data_d;
         busy_q    <= busy_d;
         listo_q   <= listo_d;
      end
   end

   assign bus.Tx_data = tx_data_q;
   assign bus.busy    = busy_q;
   assign bus.listo   = listo_q;
   assign bus.estado  = state_q;

endmodule

// File: doc/uart_8bit_tx.md
Name: uart_8bit_tx

Overview:
- Serial transmitter counterpart of the uart_8bit receiver used on the fiber links.
- Serialises one 8-bit cell-voltage byte per request into a fixed asynchronous frame: idle-high line, start bit, 8 data bits LSB first, stop bit(s).
- Drives a TXFO fiber line toward a uart_8bit receiver on the other board, or loops back into a local receiver for self-test.
- Runs in the clk_50 domain; the bit period is derived internally from a clock-count parameter.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit (50 MHz / 57600 baud); legal range 2..65535.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- IDLE_GAP, 1: extra idle-high bit times forced after the stop bit(s) before the next frame may start; legal range 0..15.

Ports:
- clk  in  1  system clock (clk_50).
- rst  in  1  asynchronous, active-high reset.
- Tx_reg  in  8  byte to transmit; sampled only on the acceptance cycle.
- send  in  1  transmit request; level-sensitive.
- Tx_data  out  1  serial line output, registered, idle high.
- busy  out  1  high from the cycle after acceptance until the frame and gap complete.
- listo  out  1  one-cycle pulse when a frame has finished, gap included.
- estado  out  3  current FSM state, for debug.

Behaviour:
- Reset values (asynchronous, active-high): Tx_data=1, busy=0, listo=0, estado=IDLE; bit counter and baud counter cleared.
- States:
  - IDLE=0: Tx_data=1, busy=0.
  - START=1: Tx_data=0.
  - DATA=2: Tx_data=shift[0].
  - STOP=3: Tx_data=1.
  - GAP=4: Tx_data=1.
- Acceptance: in IDLE with send=1 at clock edge N, Tx_reg is latched into an 8-bit shift register. From edge N+1: state=START, Tx_data=0, busy=1.
- Baud counter runs 0..CLKS_PER_BIT-1 and restarts at every state entry. Each bit is held exactly CLKS_PER_BIT cycles.
- START lasts 1 bit time, then DATA.
- DATA lasts 8 bit times. Shift right at each bit boundary; bit index counts 0..7; after index 7 go to STOP.
- STOP lasts STOP_BITS bit times. Then go to GAP if IDLE_GAP>0, otherwise to IDLE.
- GAP lasts IDLE_GAP bit times, then IDLE.
- Return to IDLE: in the first IDLE cycle, listo=1 and busy=0.
- Frame duration: busy is high for exactly (9+STOP_BITS+IDLE_GAP)*CLKS_PER_BIT cycles.
- send while busy=1 is ignored. It is not queued, and Tx_reg changes during a frame have no effect.
- Back-to-back: send=1 in the IDLE cycle where listo=1 is accepted. The next START begins on the following edge with no extra idle cycle beyond IDLE_GAP.
- send held high continuously produces continuous frames, each separated by exactly IDLE_GAP bit times plus one clk cycle.
- rst asserted mid-frame: Tx_data returns to 1 immediately. The frame is abandoned, no listo is produced, and the shift register content is discarded.
- Illegal STOP_BITS (other than 1 or 2) is treated as 1. CLKS_PER_BIT<2 is not supported; an elaboration assertion flags it.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit index 3 bits; gap/stop counter 4 bits.
- No overflow is possible within the legal parameter ranges.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants ST_IDLE..ST_GAP (3 bits).
  - Frame constant DATA_BITS=8.
  - Default CLKS_PER_BIT_50M_57600=868.
  - Function for baud counter width.
- The uart_8bit receiver uses the same state constants so that estado decodes identically on both ends.
- One natural sub-module: uart_baud_gen. Inputs: clk, rst, restart. Output: bit_end, a pulse on the last cycle of each bit period. It is parameterised by CLKS_PER_BIT and is reusable by the receiver.

Test Plan:
- Basic frame, CLKS_PER_BIT=4, STOP_BITS=1, IDLE_GAP=0; send 1 cycle with Tx_reg=0xA5 -> Tx_data shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles; busy high 40 cycles; listo one pulse on cycle 41 after acceptance.
- Reset values and mid-frame reset: rst pulse during DATA bit 3 of 0x00 -> Tx_data=1 in the same cycle, busy=0, estado=0, no listo; a new send afterwards transmits correctly.
- Ignored request: send=1 with Tx_reg=0xFF while busy transmitting 0x3C -> line still carries 0x3C only; exactly one listo.
- Back-to-back, CLKS_PER_BIT=4, STOP_BITS=2, IDLE_GAP=1; send held high, Tx_reg=0x81 then 0x7E -> two frames of 48 busy cycles each, separated by 4 idle-high gap cycles plus 1 IDLE cycle; listo pulses twice.
- Loopback to uart_8bit at default CLKS_PER_BIT with values 0, 127, 230 and 255 -> receiver Rx_reg equals each sent byte and its listo asserts once per frame.
- Random 200 bytes with random send spacing -> scoreboard matches all bytes; every bit period is exactly CLKS_PER_BIT cycles.
